// File: rtl/exit_alarm_ctrl.sv
// Checkout exit-alarm controller: synchronizes scan/clear/flag inputs, keeps saturating tallies
// and runs a latched alarm FSM with minimum-on time. Define EXIT_ALARM_BLINK_EN for a blinking LED.
module exit_alarm_ctrl #(
  parameter int unsigned ALARM_MIN_CYC  = 50000000,
  parameter int unsigned BLINK_HALF_CYC = 12500000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan_n,
  input  logic             clear_n,
  input  logic             stolen_in,
  input  logic             disc_in,
  output logic [CNT_W-1:0] item_cnt,
  output logic [CNT_W-1:0] disc_cnt,
  output logic [3:0]       stolen_cnt,
  output logic             alarm,
  output logic             alarm_led
);

  localparam int unsigned TMR_W = $clog2(ALARM_MIN_CYC + 1);
  localparam logic [TMR_W-1:0] TmrLoad = TMR_W'(ALARM_MIN_CYC - 1);

  typedef enum logic {StIdle, StAlarm} state_e;

  logic scan_s1_q, scan_s2_q, scan_s3_q;
  logic clr_s1_q, clr_s2_q;
  logic stl_s1_q, stl_s2_q;
  logic dsc_s1_q, dsc_s2_q;

  logic             scan_ev, clr, stolen, disc;
  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] item_cnt_q, item_cnt_d, disc_cnt_q, disc_cnt_d;
  logic [3:0]       stolen_cnt_q, stolen_cnt_d;
  logic             alarm_q, alarm_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_s1_q <= 1'b1;
      scan_s2_q <= 1'b1;
      scan_s3_q <= 1'b1;
      clr_s1_q  <= 1'b1;
      clr_s2_q  <= 1'b1;
      stl_s1_q  <= 1'b0;
      stl_s2_q  <= 1'b0;
      dsc_s1_q  <= 1'b0;
      dsc_s2_q  <= 1'b0;
    end else begin
      scan_s1_q <= scan_n;
      scan_s2_q <= scan_s1_q;
      scan_s3_q <= scan_s2_q;
      clr_s1_q  <= clear_n;
      clr_s2_q  <= clr_s1_q;
      stl_s1_q  <= stolen_in;
      stl_s2_q  <= stl_s1_q;
      dsc_s1_q  <= disc_in;
      dsc_s2_q  <= dsc_s1_q;
    end
  end

  // One event per synchronized falling edge of the scan button.
  assign scan_ev = scan_s3_q & ~scan_s2_q;
  assign clr     = ~clr_s2_q;
  assign stolen  = stl_s2_q;
  assign disc    = dsc_s2_q;

  always_comb begin
    item_cnt_d   = item_cnt_q;
    disc_cnt_d   = disc_cnt_q;
    stolen_cnt_d = stolen_cnt_q;
    if (scan_ev) begin
      if (item_cnt_q != '1) item_cnt_d = item_cnt_q + CNT_W'(1);
      if (disc && (disc_cnt_q != '1)) disc_cnt_d = disc_cnt_q + CNT_W'(1);
      if (stolen && (stolen_cnt_q != '1)) stolen_cnt_d = stolen_cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      StIdle: begin
        if (scan_ev && stolen) begin
          state_d = StAlarm;
          tmr_d   = TmrLoad;
        end
      end
      StAlarm: begin
        // A fresh stolen scan wins over a clear in the same cycle.
        if (scan_ev && stolen) begin
          tmr_d = TmrLoad;
        end else if (tmr_q == '0) begin
          if (clr) state_d = StIdle;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
    endcase
    alarm_d = (state_d == StAlarm);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      tmr_q        <= '0;
      item_cnt_q   <= '0;
      disc_cnt_q   <= '0;
      stolen_cnt_q <= '0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      item_cnt_q   <= item_cnt_d;
      disc_cnt_q   <= disc_cnt_d;
      stolen_cnt_q <= stolen_cnt_d;
      alarm_q      <= alarm_d;
    end
  end

`ifdef EXIT_ALARM_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF_CYC + 1);
  localparam logic [BLINK_W-1:0] BlinkLast = BLINK_W'(BLINK_HALF_CYC - 1);

  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               led_q, led_d;

  always_comb begin
    blink_d = blink_q;
    led_d   = led_q;
    if (state_d == StAlarm) begin
      if (state_q == StIdle) begin
        led_d   = 1'b1;
        blink_d = '0;
      end else if (blink_q == BlinkLast) begin
        led_d   = ~led_q;
        blink_d = '0;
      end else begin
        blink_d = blink_q + BLINK_W'(1);
      end
    end else begin
      led_d   = 1'b0;
      blink_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_q <= '0;
      led_q   <= 1'b0;
    end else begin
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end

  assign alarm_led = led_q;
`else
  assign alarm_led = alarm_q;
`endif

  assign item_cnt   = item_cnt_q;
  assign disc_cnt   = disc_cnt_q;
  assign stolen_cnt = stolen_cnt_q;
  assign alarm      = alarm_q;

endmodule
